// File: rtl/zsy_disp_pkg.sv
// zsy_disp_pkg
// Shared constants and types for the zsy_cp1 four-digit seven-segment
// scan controller: blank/off patterns, the digit-index type and the
// hex-to-segment glyph table (segments {g,f,e,d,c,b,a}, active-low).
package zsy_disp_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] DIG_OFF   = 4'hF;

   typedef logic [1:0] dig_idx_t;

   localparam dig_idx_t IDX_LAST = 2'd3;

   // Element [n] is the glyph for hex digit n.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E,   // F
      7'h06,   // E
      7'h21,   // d
      7'h46,   // C
      7'h03,   // b
      7'h08,   // A
      7'h10,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

endpackage

// File: rtl/zsy_disp_scan_hex7seg.sv
// zsy_hex7seg
// Purely combinational hex-to-seven-segment decoder, active-low outputs.
// Ports:
//   nib  in  4 : hex digit
//   seg  out 7 : segments {g,f,e,d,c,b,a}, 0 = lit
module zsy_hex7seg
   import zsy_disp_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nib];

endmodule

// File: rtl/zsy_disp_scan.sv
// zsy_disp_scan
// Time-multiplexed scan controller for the four-digit common-anode
// seven-segment display. Holds a 16-bit image plus four decimal points and
// lights one digit per slot of CLK_DIV cycles. A req/ack handshake swaps
// in a new image only at a frame boundary, so frames are never torn.
//
// Build option: define ZSY_LZB_EN for leading-zero blanking of dig1..dig3.
//
// Ports:
//   CP          in  1  : clock, rising edge
//   MR          in  1  : asynchronous reset, active-low
//   val         in  16 : image, [15:12] -> dig1 ... [3:0] -> dig4
//   dp_in       in  4  : decimal points, bit 3 -> dig1 ... bit 0 -> dig4
//   upd_req     in  1  : update request, held until upd_ack
//   upd_ack     out 1  : one-cycle pulse, image accepted
//   dig1..dig4  out 1  : digit enables, active-low
//   Y           out 7  : segments {g,f,e,d,c,b,a}, active-low
//   dp          out 1  : decimal point, active-low
//   frame       out 1  : one-cycle pulse per frame boundary
//
// State table (scan position, advanced on tick):
//   idx | meaning
//   0   | dig1 slot (frame start)
//   1   | dig2 slot
//   2   | dig3 slot
//   3   | dig4 slot; tick here is the frame boundary (reset state)
module zsy_disp_scan
   import zsy_disp_pkg::*;
#(
   parameter int CLK_DIV = 2500
)(
   input  logic        CP,
   input  logic        MR,
   input  logic [15:0] val,
   input  logic [3:0]  dp_in,
   input  logic        upd_req,
   output logic        upd_ack,
   output logic        dig1,
   output logic        dig2,
   output logic        dig3,
   output logic        dig4,
   output logic [6:0]  Y,
   output logic        dp,
   output logic        frame
);

   localparam int            PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PC_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] pc;
   dig_idx_t      idx;
   dig_idx_t      idx_nx;
   logic [15:0]   disp;
   logic [15:0]   disp_nx;
   logic [3:0]    dpr;
   logic [3:0]    dpr_nx;
   logic          tick;
   logic          fb;
   logic          load;
   logic [3:0]    nib;
   logic          dp_sel;
   logic [6:0]    seg;
   logic          blank;
   logic [3:0]    dig_r;

   assign tick = (pc == PC_LAST);
   assign fb   = tick && (idx == IDX_LAST);
   assign load = fb && upd_req;

   // Outputs are driven from next-state values so that an image accepted
   // at the frame boundary already shows on dig1 at that same edge.
   always_comb begin
      idx_nx  = idx + 2'd1;
      disp_nx = load ? val   : disp;
      dpr_nx  = load ? dp_in : dpr;
   end

   always_comb begin
      nib    = disp_nx[3:0];
      dp_sel = dpr_nx[0];
      case (idx_nx)
         2'd0: begin nib = disp_nx[15:12]; dp_sel = dpr_nx[3]; end
         2'd1: begin nib = disp_nx[11:8];  dp_sel = dpr_nx[2]; end
         2'd2: begin nib = disp_nx[7:4];   dp_sel = dpr_nx[1]; end
         default: begin nib = disp_nx[3:0]; dp_sel = dpr_nx[0]; end
      endcase
   end

   zsy_hex7seg u_dec (
      .nib (nib),
      .seg (seg)
   );

`ifdef ZSY_LZB_EN
   // A digit is blank while every digit from dig1 up to and including it is
   // zero with its decimal point off; dig4 always shows.
   always_comb begin
      logic lead;
      lead  = 1'b1;
      blank = 1'b0;
      for (int k = 0; k < 3; k++) begin
         lead = lead && (disp_nx[15-4*k -: 4] == 4'h0) && !dpr_nx[3-k];
         if (idx_nx == dig_idx_t'(k)) blank = lead;
      end
   end
`else
   assign blank = 1'b0;
`endif

   always_ff @(posedge CP or negedge MR) begin
      if (!MR) begin
         pc      <= '0;
         idx     <= IDX_LAST;
         disp    <= '0;
         dpr     <= '0;
         dig_r   <= DIG_OFF;
         Y       <= SEG_BLANK;
         dp      <= 1'b1;
         upd_ack <= 1'b0;
         frame   <= 1'b0;
      end else begin
         upd_ack <= load;
         frame   <= fb;
         if (tick) begin
            pc   <= '0;
            idx  <= idx_nx;
            disp <= disp_nx;
            dpr  <= dpr_nx;
            if (blank) begin
               dig_r <= DIG_OFF;
               Y     <= SEG_BLANK;
               dp    <= 1'b1;
            end else begin
               dig_r <= ~(4'b1000 >> idx_nx);
               Y     <= seg;
               dp    <= ~dp_sel;
            end
         end else begin
            pc <= pc + PW'(1);
         end
      end
   end

   assign dig1 = dig_r[3];
   assign dig2 = dig_r[2];
   assign dig3 = dig_r[1];
   assign dig4 = dig_r[0];

endmodule
